// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit ripple-carry slice reused once per cycle,
// with a valid/ready handshake on both operand and result sides.

module nibble_rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] sum,
    output logic       cout
);
    logic c1;
    logic c2;
    logic c3;

    assign sum[0] = a[0] ^ b[0] ^ c;
    assign c1     = (a[0] & b[0]) | (c & (a[0] ^ b[0]));
    assign sum[1] = a[1] ^ b[1] ^ c1;
    assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    assign sum[2] = a[2] ^ b[2] ^ c2;
    assign c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
    assign sum[3] = a[3] ^ b[3] ^ c3;
    assign cout   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 overflow,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic [CW-1:0] idx;
    logic          carry;
    logic          fin;
    logic          cout_q;
    logic          ovf_q;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_s;
    logic       nib_c;

    assign nib_a = a_q[4*idx +: 4];
    assign nib_b = b_q[4*idx +: 4];

    nibble_rca u_rca (
        .a    (nib_a),
        .b    (nib_b),
        .c    (carry),
        .sum  (nib_s),
        .cout (nib_c)
    );

    // fin marks that the top nibble is written; the following edge
    // enters DONE and samples flags from the complete sum register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            fin    <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= c;
                        idx   <= '0;
                        sum_q <= '0;
                        fin   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!fin) begin
                        sum_q[4*idx +: 4] <= nib_s;
                        carry             <= nib_c;
                        if (idx == LAST) begin
                            fin <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cout_q <= carry;
                        ovf_q  <= (a_q[W-1] == b_q[W-1])
                               && (sum_q[W-1] != a_q[W-1]);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: reset, arithmetic corners,
// latency, backpressure, mid-run reset and a run of random operands.

module tb_nibble_serial_adder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge; returns just after the accepting edge.
    task automatic start(input logic [15:0] va, input logic [15:0] vb,
                         input logic vc);
        check("ready_before_start", in_ready, 1);
        a = va;
        b = vb;
        c = vc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_valid"}, out_valid, 1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] es,
                                input logic eco, input logic eov);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, eco);
        check({tag, "_ovf"}, overflow, eov);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ready_after_hs", in_ready, 1);
    endtask

    task automatic op(input string tag, input logic [15:0] va,
                      input logic [15:0] vb, input logic vc,
                      input logic [15:0] es, input logic eco,
                      input logic eov);
        start(va, vb, vc);
        wait_done(tag);
        check_result(tag, es, eco, eov);
        handshake();
    endtask

    initial begin
        logic [16:0] full;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        eov;
        int          stall;
        bit          seen;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        c = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);

        op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op("negovf", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
        op("cin", 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);

        // Backpressure with a pending operand held on the input.
        start(16'h1234, 16'h4321, 1'b0);
        wait_done("bp_first");
        a = 16'hAAAA;
        b = 16'h1111;
        c = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_sum", sum, 16'h5555);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_after_hs", busy, 0);
        check("bp_ready_after_hs", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_accepted", busy, 1);
        wait_done("bp_second");
        check_result("bp_second", 16'hBBBB, 1'b0, 1'b0);
        handshake();

        // Reset asserted on the second RUN edge.
        start(16'h1234, 16'h1111, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            eov = (ra[15] == rb[15]) && (full[15] != ra[15]);
            start(ra, rb, rc);
            wait_done("rand");
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                tick();
                check("rand_stall_valid", out_valid, 1);
            end
            check_result("rand", full[15:0], full[16], eov);
            handshake();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
